// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and its encoding width.
package serial_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a requester (master) and the serial subtractor (slave).
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    // start is a request taken only while idle or on the done cycle; done is a
    // one-cycle pulse after which diff/bout stay valid until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );

endinterface

// File: rtl/serial_sub_fs.sv
// Combinational full subtractor cell: d = a - b - bin, with borrow out.
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
module serial_sub
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  io,
    output state_t       dbg_state
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   diff_sr;
    logic [CNT_W-1:0]   cnt;
    logic               br;
    logic               bout_r;
    logic               d_bit;
    logic               bo_bit;

    fs u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (br),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start is honoured in IDLE and on the DONE cycle, giving back-to-back operation.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (io.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (io.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            bout_r  <= 1'b0;
        end else if (accept) begin
            a_sr    <= io.a;
            b_sr    <= io.b;
            diff_sr <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            bout_r  <= 1'b0;
        end else if (state == SHIFT) begin
            // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            br      <= bo_bit;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST) begin
                bout_r <= bo_bit;
            end
        end
    end

    assign io.busy   = (state == SHIFT);
    assign io.done   = (state == DONE);
    assign io.diff   = diff_sr;
    assign io.bout   = bout_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_sub.sv
// Randomised and directed bench for serial_sub with a queue-based scoreboard and arithmetic reference.
module tb_serial_sub;
    import serial_pkg::*;

    localparam int WIDTH = 8;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    serial_sub_if #(.WIDTH(WIDTH)) io ();

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (io),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [WIDTH:0] exp_q[$];     // {bout, diff}
    int             exp_n_q[$];   // negedge index at which done must appear
    int             n = 0;        // negedges seen
    int             rst_req = 0;  // bumped by the driver after each reset release
    int             rst_seen = 0;
    int             busy_run = 0;
    int             total = 0;
    int             bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        int             en;
        n++;
        if (rst) begin
            exp_q.delete();
            exp_n_q.delete();
            busy_run = 0;
        end else begin
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                chk("idle_busy", int'(io.busy), 0);
                chk("idle_done", int'(io.done), 0);
                chk("idle_diff", int'(io.diff), 0);
                chk("idle_bout", int'(io.bout), 0);
                chk("idle_state", int'(dbg_state), int'(IDLE));
            end
            if (io.busy) busy_run++;
            if (io.done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    en = exp_n_q.pop_front();
                    chk("diff", int'(io.diff), int'(e[WIDTH-1:0]));
                    chk("bout", int'(io.bout), int'(e[WIDTH]));
                    chk("done_cycle", n, en);
                    chk("busy_cycles", busy_run, WIDTH);
                end
                busy_run = 0;
            end else if (exp_n_q.size() > 0 && n > exp_n_q[0]) begin
                chk("done_timeout", 0, 1);
                void'(exp_q.pop_front());
                void'(exp_n_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned d;
        d = (int'(x) - int'(y) + (1 << WIDTH)) % (1 << WIDTH);
        return {(x < y), WIDTH'(d)};
    endfunction

    // Raises start with operands, waits for the accepting edge, then scrambles the inputs.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        io.start = 1'b1;
        io.a     = x;
        io.b     = y;
        @(posedge clk);
        exp_q.push_back(ref_sub(x, y));
        exp_n_q.push_back(n + WIDTH + 1);
        #1;
        io.start = 1'b0;
        io.a     = WIDTH'($urandom);
        io.b     = WIDTH'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!io.done && k < 4 * WIDTH);
    endtask

    task automatic gap(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_req++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        io.start = 1'b0;
        io.a     = '0;
        io.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_req++;
        gap(2);

        launch(8'd100, 8'd37); wait_done(); gap(1);
        launch(8'd5, 8'd9); wait_done(); gap(1);
        launch(8'h00, 8'hFF); wait_done(); gap(1);
        launch(8'hAA, 8'hAA); wait_done(); gap(2);

        // start pulsed mid-shift with different operands must be ignored
        launch(8'd77, 8'd12);
        gap(3);
        io.start = 1'b1;
        io.a     = 8'd1;
        io.b     = 8'd250;
        gap(1);
        io.start = 1'b0;
        wait_done(); gap(2);

        // start held high through the done cycle: second operation follows immediately
        launch(8'd50, 8'd20);
        io.start = 1'b1;
        io.a     = 8'd200;
        io.b     = 8'd1;
        wait_done();
        @(posedge clk);
        exp_q.push_back(ref_sub(8'd200, 8'd1));
        exp_n_q.push_back(n + WIDTH + 1);
        #1;
        io.start = 1'b0;
        wait_done(); gap(2);

        // reset during bit 4 aborts the run without a done pulse
        launch(8'd123, 8'd45);
        gap(4);
        do_reset();
        gap(3);
        launch(8'd9, 8'd200); wait_done(); gap(1);

        // randomised operands, mixing back-to-back and idle gaps
        for (int i = 0; i < 40; i++) begin
            launch(WIDTH'($urandom), WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
            wait_done();
            if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 3));
        end
        launch(8'hFF, 8'h00);
        wait_done();

        gap(3 * WIDTH);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
